// File: rtl/pc_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_gen_pkg : shared defaults and FSM encoding for the fetch PC gen.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_gen_pkg;

  localparam int          c_xlen_default       = 32;
  localparam logic [31:0] c_reset_pc_default   = 32'h0000_0000;
  localparam int          c_inst_bytes_default = 4;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_btb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_btb : direct-mapped branch target buffer, combinational lookup.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_btb #(
  parameter int XLEN        = 32,
  parameter int INST_BYTES  = 4,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic            hit,
  output logic [XLEN-1:0] target
);

  localparam int c_off_w = $clog2(INST_BYTES);
  localparam int c_idx_w = $clog2(BTB_ENTRIES);
  localparam int c_tag_w = XLEN - c_idx_w - c_off_w;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [c_tag_w-1:0]     r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];

  logic [c_idx_w-1:0] w_lk_idx;
  logic [c_tag_w-1:0] w_lk_tag;
  logic [c_idx_w-1:0] w_up_idx;
  logic [c_tag_w-1:0] w_up_tag;
  logic               w_unused_lsb;

  assign w_lk_idx = lookup_pc[c_idx_w+c_off_w-1:c_off_w];
  assign w_lk_tag = lookup_pc[XLEN-1:c_idx_w+c_off_w];
  assign w_up_idx = upd_pc[c_idx_w+c_off_w-1:c_off_w];
  assign w_up_tag = upd_pc[XLEN-1:c_idx_w+c_off_w];
  // Byte-offset bits never participate in index or tag.
  assign w_unused_lsb = ^{lookup_pc, upd_pc};

  assign hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign target = r_target[w_lk_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
      end else if (r_tag[w_up_idx] == w_up_tag) begin
        r_valid[w_up_idx] <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_gen : fetch PC generator with redirect, stall and BTB prediction. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = c_xlen_default,
  parameter logic [XLEN-1:0] RESET_PC    = c_reset_pc_default,
  parameter int              INST_BYTES  = c_inst_bytes_default,
  parameter int              BTB_ENTRIES = 16,
  parameter bit              BTB_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            if_ready,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken
);

  localparam logic [XLEN-1:0] c_align_mask = ~(XLEN'(INST_BYTES - 1));
  localparam logic [XLEN-1:0] c_step       = XLEN'(INST_BYTES);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_accept;
  logic            w_hit;
  logic [XLEN-1:0] w_btb_target;

  generate
    if (BTB_EN) begin : g_btb
      pc_btb #(
        .XLEN        (XLEN),
        .INST_BYTES  (INST_BYTES),
        .BTB_ENTRIES (BTB_ENTRIES)
      ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (r_pc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .hit        (w_hit),
        .target     (w_btb_target)
      );
    end else begin : g_no_btb
      logic w_unused_upd;
      assign w_unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
      assign w_hit        = 1'b0;
      assign w_btb_target = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Redirect outranks everything, including a stall, so it is never lost.
  always_comb begin
    w_state_nxt = ST_RUN;
    pc_valid    = (r_state == ST_RUN);
    w_accept    = pc_valid && if_ready;
    w_pc_nxt    = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc & c_align_mask;
    end else if (w_accept && w_hit) begin
      w_pc_nxt = w_btb_target;
    end else if (w_accept) begin
      w_pc_nxt = r_pc + c_step;
    end
  end

  assign pc_o       = r_pc;
  assign pred_taken = w_hit && pc_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_gen : directed self-checking bench for pc_gen.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        if_ready;
  logic        pc_valid;
  logic [31:0] pc_o;
  logic        pred_taken;

  int n_checks;
  int n_fail;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .if_ready       (if_ready),
    .pc_valid       (pc_valid),
    .pc_o           (pc_o),
    .pred_taken     (pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc,
                           input logic e_valid, input logic e_pred);
    check({tag, ".pc"},    pc_o,               e_pc);
    check({tag, ".valid"}, {31'd0, pc_valid},   {31'd0, e_valid});
    check({tag, ".pred"},  {31'd0, pred_taken}, {31'd0, e_pred});
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    if_ready = 1'b1;

    // Reset and boot
    step(); step(); step();
    check_out("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    check_out("boot", 32'h0, 1'b0, 1'b0);
    step(); check_out("run0", 32'h0, 1'b1, 1'b0);
    step(); check_out("run4", 32'h4, 1'b1, 1'b0);
    step(); check_out("run8", 32'h8, 1'b1, 1'b0);
    step(); step(); check_out("run10", 32'h10, 1'b1, 1'b0);

    // Stall holds pc_o
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); check_out("stall", 32'h10, 1'b1, 1'b0);
    end
    if_ready = 1'b1;
    step(); check_out("unstall", 32'h14, 1'b1, 1'b0);

    // Redirect under stall, misaligned target
    redirect_to(32'h20);
    step(); check_out("redir20", 32'h20, 1'b1, 1'b0);
    if_ready = 1'b0;
    redirect_to(32'h103);
    step(); check_out("redir_stall", 32'h100, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    step(); check_out("redir_hold", 32'h100, 1'b1, 1'b0);
    if_ready = 1'b1;
    step(); check_out("redir_seq", 32'h104, 1'b1, 1'b0);

    // Train 0x40 -> 0x200 together with a redirect to 0x40
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h200;
    redirect_to(32'h40);
    step(); upd_valid = 1'b0; redirect_valid = 1'b0;
    check_out("hit40", 32'h40, 1'b1, 1'b1);
    step(); check_out("tgt200", 32'h200, 1'b1, 1'b0);

    // Untrain 0x40
    upd_valid = 1'b1; upd_taken = 1'b0;
    redirect_to(32'h40);
    step(); upd_valid = 1'b0; redirect_valid = 1'b0;
    check_out("untrain40", 32'h40, 1'b1, 1'b0);
    step(); check_out("seq44", 32'h44, 1'b1, 1'b0);

    // Alias: same index, different tag
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h200;
    redirect_to(32'h80);
    step(); upd_valid = 1'b0; redirect_valid = 1'b0;
    check_out("alias80", 32'h80, 1'b1, 1'b0);
    step(); check_out("alias84", 32'h84, 1'b1, 1'b0);
    redirect_to(32'h40);
    step(); redirect_valid = 1'b0;
    check_out("rehit40", 32'h40, 1'b1, 1'b1);

    // Same-cycle untrain: lookup this cycle still sees the old entry
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
    step(); upd_valid = 1'b0;
    check_out("old_contents", 32'h200, 1'b1, 1'b0);

    // Wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    step(); redirect_valid = 1'b0;
    check_out("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(); check_out("wrap", 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-run wipes the BTB
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h200;
    redirect_to(32'h300);
    step(); upd_valid = 1'b0; redirect_valid = 1'b0;
    check_out("pc300", 32'h300, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 check_out("async_rst", 32'h0, 1'b0, 1'b0);
    step(); rst = 1'b1;
    check_out("reboot", 32'h0, 1'b0, 1'b0);
    redirect_to(32'h40);
    step(); redirect_valid = 1'b0;
    check_out("boot_redir", 32'h40, 1'b1, 1'b0);
    step(); check_out("post_rst44", 32'h44, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
